// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: MemOp encoding from the decoder and the LSU state encoding.
package riscv_pkg;

   localparam logic [2:0] MEMOP_B  = 3'b000;
   localparam logic [2:0] MEMOP_BU = 3'b001;
   localparam logic [2:0] MEMOP_H  = 3'b010;
   localparam logic [2:0] MEMOP_HU = 3'b011;
   localparam logic [2:0] MEMOP_W  = 3'b100;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_RESP = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication, load extract/extension
// and detection of illegal or misaligned commands.
module lsu_align
   import riscv_pkg::*;
(
   input  logic        st_we,
   input  logic [2:0]  st_memop,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_lane,
   output logic        st_illegal,
   output logic        st_misaligned,
   input  logic [2:0]  ld_memop,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift;

   always_comb begin
      st_be         = 4'b0000;
      st_lane       = 32'h0;
      st_illegal    = 1'b0;
      st_misaligned = 1'b0;
      case (st_memop)
         MEMOP_B, MEMOP_BU: begin
            st_be   = 4'b0001 << st_off;
            st_lane = {4{st_wdata[7:0]}};
         end
         MEMOP_H, MEMOP_HU: begin
            st_be         = st_off[1] ? 4'b1100 : 4'b0011;
            st_lane       = {2{st_wdata[15:0]}};
            st_misaligned = st_off[0];
         end
         MEMOP_W: begin
            st_be         = 4'b1111;
            st_lane       = st_wdata;
            st_misaligned = |st_off;
         end
         default: st_illegal = 1'b1;
      endcase
      // Unsigned variants only make sense for loads.
      if (st_we && (st_memop == MEMOP_BU || st_memop == MEMOP_HU))
         st_illegal = 1'b1;
      if (!st_we)
         st_lane = 32'h0;
   end

   assign ld_shift = ld_rdata >> {ld_off, 3'b000};

   always_comb begin
      case (ld_memop)
         MEMOP_B:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         MEMOP_BU: ld_data = {24'h0, ld_shift[7:0]};
         MEMOP_H:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         MEMOP_HU: ld_data = {16'h0, ld_shift[15:0]};
         default:  ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one word-aligned bus transaction per command with
// request/grant/response handshake, timeout, and extended load data return.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_memop,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   lsu_state_e  state, state_nxt;
   logic [CW-1:0] cnt;
   logic        we_q;
   logic [2:0]  memop_q;
   logic [1:0]  off_q;

   logic [3:0]  st_be;
   logic [31:0] st_lane;
   logic        st_illegal, st_misaligned;
   logic [31:0] ld_data;
   logic        cmd_bad, timeout;

   lsu_align u_align (
      .st_we         (req_we),
      .st_memop      (req_memop),
      .st_off        (req_addr[1:0]),
      .st_wdata      (req_wdata),
      .st_be         (st_be),
      .st_lane       (st_lane),
      .st_illegal    (st_illegal),
      .st_misaligned (st_misaligned),
      .ld_memop      (memop_q),
      .ld_off        (off_q),
      .ld_rdata      (bus_rdata),
      .ld_data       (ld_data)
   );

   assign cmd_bad = st_illegal | st_misaligned;
   // The counter value is the number of REQ/WAIT cycles already spent, so this
   // cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
   assign timeout = (cnt >= CW'(TIMEOUT - 1));

   assign req_ready  = (state == LSU_IDLE);
   assign resp_valid = (state == LSU_RESP);
   assign bus_req    = (state == LSU_REQ);

   always_comb begin
      state_nxt = state;
      case (state)
         LSU_IDLE: if (req_valid) state_nxt = cmd_bad ? LSU_RESP : LSU_REQ;
         LSU_REQ: begin
            if (bus_gnt)      state_nxt = LSU_WAIT;
            else if (timeout) state_nxt = LSU_RESP;
         end
         LSU_WAIT: if (bus_rvalid || timeout) state_nxt = LSU_RESP;
         LSU_RESP: state_nxt = LSU_IDLE;
         default:  state_nxt = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LSU_IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         memop_q    <= 3'b000;
         off_q      <= 2'b00;
         bus_we     <= 1'b0;
         bus_addr   <= 32'h0;
         bus_be     <= 4'b0000;
         bus_wdata  <= 32'h0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            LSU_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  memop_q <= req_memop;
                  off_q   <= req_addr[1:0];
                  if (cmd_bad) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else begin
                     bus_we    <= req_we;
                     bus_addr  <= {req_addr[31:2], 2'b00};
                     bus_be    <= st_be;
                     bus_wdata <= st_lane;
                     cnt       <= '0;
                  end
               end
            end
            LSU_REQ, LSU_WAIT: begin
               cnt <= cnt + 1'b1;
               // A response arriving in the timeout cycle still wins.
               if (state == LSU_WAIT && bus_rvalid) begin
                  resp_rdata <= we_q ? 32'h0 : ld_data;
                  resp_err   <= 1'b0;
               end else if (state_nxt == LSU_RESP) begin
                  resp_rdata <= 32'h0;
                  resp_err   <= 1'b1;
               end
            end
            default: begin
               resp_rdata <= 32'h0;
               resp_err   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// commands checked against a behavioural model of the memory command rules.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_memop;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        bus_req, bus_we, bus_gnt, bus_rvalid;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int n_checks = 0;
   int n_fail   = 0;

   int          obs_resp_cyc, obs_req_cycles;
   logic        obs_bus_seen, obs_stable, obs_req_after_gnt;
   logic        obs_after_valid, obs_after_ready;
   logic        obs_err, obs_we;
   logic [31:0] obs_rdata, obs_addr, obs_wdata;
   logic [3:0]  obs_be;

   load_store_unit #(.TIMEOUT(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_memop  (req_memop),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_gnt    (bus_gnt),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   always #5 clk = ~clk;

   // Reference model: derived from access size and byte offset with plain arithmetic.
   task automatic model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        output logic err, output logic [3:0] be,
                        output logic [31:0] wd, output logic [31:0] rd);
      int size, off;
      logic [31:0] v;
      off  = int'(addr % 4);
      size = (op == 3'd4) ? 4 : ((op == 3'd2 || op == 3'd3) ? 2 : 1);
      err  = (op > 3'd4) || (we && (op == 3'd1 || op == 3'd3)) || (off % size != 0);
      be   = 4'(((1 << size) - 1) << off);
      if (!we)            wd = 32'h0;
      else if (size == 1) wd = {24'h0, wdata[7:0]} * 32'h01010101;
      else if (size == 2) wd = {16'h0, wdata[15:0]} * 32'h00010001;
      else                wd = wdata;
      v = rdata / (32'd1 << (8 * off));
      if (size == 1) begin
         v = v % 256;
         if (op == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
      end else if (size == 2) begin
         v = v % 65536;
         if (op == 3'd2 && v >= 32768) v = v + 32'hFFFF0000;
      end
      rd = (we || err) ? 32'h0 : v;
   endtask

   // Drives one command and plays the bus side; records what was observed.
   task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata);
      int guard, phase, k;
      obs_resp_cyc = -1; obs_req_cycles = 0; obs_bus_seen = 1'b0; obs_stable = 1'b1;
      obs_req_after_gnt = 1'b0; obs_after_valid = 1'b1; obs_after_ready = 1'b0;
      obs_rdata = 32'hX; obs_err = 1'bX;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      req_valid = 1'b1; req_we = we; req_memop = op; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
      phase = 0; k = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
         if (resp_valid) begin
            obs_resp_cyc = cyc; obs_rdata = resp_rdata; obs_err = resp_err;
            break;
         end
         if (bus_req || phase == 1) begin
            if (!obs_bus_seen) begin
               obs_bus_seen = 1'b1; obs_addr = bus_addr; obs_be = bus_be;
               obs_we = bus_we; obs_wdata = bus_wdata;
            end else if (bus_addr !== obs_addr || bus_be !== obs_be ||
                         bus_we !== obs_we || bus_wdata !== obs_wdata) begin
               obs_stable = 1'b0;
            end
         end
         if (bus_req) begin
            obs_req_cycles++;
            if (phase != 0) obs_req_after_gnt = 1'b1;
         end
         if (phase == 0 && bus_req) begin
            if (k == gnt_dly) begin bus_gnt = 1'b1; phase = 1; k = 0; end
            else k++;
         end else if (phase == 1) begin
            if (k == rv_dly) begin bus_rvalid = 1'b1; bus_rdata = rdata; phase = 2; end
            else k++;
         end
         @(posedge clk); #1;
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (obs_resp_cyc > 0) begin
         @(posedge clk); #1;
         obs_after_valid = resp_valid; obs_after_ready = req_ready;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_memop = 3'd4;
      req_addr = 32'h100; req_wdata = 32'h0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
      n_checks++;
      if ({resp_valid, resp_err, bus_req, bus_we} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {resp_valid, resp_err, bus_req, bus_we});
      end
      n_checks++;
      if ({resp_rdata, bus_addr, bus_wdata, bus_be} !== 100'h0) begin
         n_fail++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h be=%b expected all 0",
                            resp_rdata, bus_addr, bus_wdata, bus_be);
      end
      rst_n = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({bus_req, resp_valid, req_ready} !== 3'b001) begin
         n_fail++; $display("FAIL reset_no_accept: got req/valid/ready=%b expected 001", {bus_req, resp_valid, req_ready});
      end
   endtask

   task automatic test_sw;
      run_txn(1'b1, 3'd4, 32'h1000, 32'hDEADBEEF, 0, 0, 32'h0);
      n_checks++;
      if (obs_resp_cyc !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d expected 3", obs_resp_cyc); end
      n_checks++;
      if ({obs_addr, obs_be, obs_wdata, obs_we} !== {32'h1000, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
         n_fail++; $display("FAIL sw_bus: got addr=%h be=%b wdata=%h we=%b expected 1000/1111/deadbeef/1",
                            obs_addr, obs_be, obs_wdata, obs_we);
      end
      n_checks++;
      if ({obs_err, obs_rdata} !== 33'h0) begin
         n_fail++; $display("FAIL sw_resp: got err=%b rdata=%h expected 0/0", obs_err, obs_rdata);
      end
      n_checks++;
      if ({obs_after_valid, obs_after_ready, obs_req_after_gnt} !== 3'b010) begin
         n_fail++; $display("FAIL sw_pulse: got valid/ready/req_after_gnt=%b expected 010",
                            {obs_after_valid, obs_after_ready, obs_req_after_gnt});
      end
   endtask

   task automatic test_sb;
      run_txn(1'b1, 3'd0, 32'h1003, 32'h000000A5, 0, 0, 32'h0);
      n_checks++;
      if ({obs_addr, obs_be, obs_wdata} !== {32'h1000, 4'b1000, 32'hA5A5A5A5}) begin
         n_fail++; $display("FAIL sb_bus: got addr=%h be=%b wdata=%h expected 1000/1000/a5a5a5a5",
                            obs_addr, obs_be, obs_wdata);
      end
      n_checks++;
      if (obs_err !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b expected 0", obs_err); end
   endtask

   task automatic test_loads;
      logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
      logic [31:0] exps[4] = '{32'hFFFFFFF4, 32'h000000F4, 32'h000012F4, 32'h000012F4};
      for (int i = 0; i < 4; i++) begin
         run_txn(1'b0, ops[i], 32'h2002, 32'hFFFFFFFF, 0, 0, 32'h12F45678);
         n_checks++;
         if (obs_rdata !== exps[i] || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL load_op%0d: got rdata=%h err=%b expected %h/0", ops[i], obs_rdata, obs_err, exps[i]);
         end
         n_checks++;
         if (obs_wdata !== 32'h0 || obs_we !== 1'b0) begin
            n_fail++; $display("FAIL load_bus_op%0d: got wdata=%h we=%b expected 0/0", ops[i], obs_wdata, obs_we);
         end
      end
   endtask

   task automatic test_errors;
      run_txn(1'b0, 3'd4, 32'h3001, 32'h0, 0, 0, 32'h0);
      n_checks++;
      if (obs_resp_cyc !== 1 || obs_err !== 1'b1 || obs_bus_seen !== 1'b0 || obs_rdata !== 32'h0) begin
         n_fail++; $display("FAIL err_misaligned: got cyc=%0d err=%b bus=%b rdata=%h expected 1/1/0/0",
                            obs_resp_cyc, obs_err, obs_bus_seen, obs_rdata);
      end
      run_txn(1'b1, 3'd3, 32'h3000, 32'h1234, 0, 0, 32'h0);
      n_checks++;
      if (obs_resp_cyc !== 1 || obs_err !== 1'b1 || obs_bus_seen !== 1'b0) begin
         n_fail++; $display("FAIL err_illegal: got cyc=%0d err=%b bus=%b expected 1/1/0",
                            obs_resp_cyc, obs_err, obs_bus_seen);
      end
   endtask

   task automatic test_timeout;
      run_txn(1'b0, 3'd4, 32'h5000, 32'h0, 1000, 0, 32'h0);
      n_checks++;
      if (obs_req_cycles !== 8 || obs_resp_cyc !== 9) begin
         n_fail++; $display("FAIL timeout_len: got req_cycles=%0d resp_cyc=%0d expected 8/9", obs_req_cycles, obs_resp_cyc);
      end
      n_checks++;
      if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
         n_fail++; $display("FAIL timeout_resp: got err=%b rdata=%h expected 1/0", obs_err, obs_rdata);
      end
      bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'hCAFEF00D;
      repeat (2) begin
         @(posedge clk); #1;
         n_checks++;
         if ({resp_valid, bus_req, req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL timeout_late_rvalid: got valid/req/ready=%b expected 001", {resp_valid, bus_req, req_ready});
         end
      end
      bus_rvalid = 1'b0; bus_gnt = 1'b0;
   endtask

   task automatic test_reset_mid;
      req_valid = 1'b1; req_we = 1'b0; req_memop = 3'd4; req_addr = 32'h4000;
      @(posedge clk); #1;
      req_valid = 1'b0; bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, resp_valid, resp_err, bus_req, bus_we, bus_be, bus_addr, bus_wdata, resp_rdata} !== {1'b1, 104'h0}) begin
         n_fail++; $display("FAIL reset_mid: got ready=%b valid=%b req=%b be=%b addr=%h expected 1/0/0/0/0",
                            req_ready, resp_valid, bus_req, bus_be, bus_addr);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_txn(1'b0, 3'd4, 32'h4004, 32'h0, 0, 1, 32'h89ABCDEF);
      n_checks++;
      if (obs_rdata !== 32'h89ABCDEF || obs_err !== 1'b0 || obs_resp_cyc !== 4) begin
         n_fail++; $display("FAIL reset_mid_after: got rdata=%h err=%b cyc=%0d expected 89abcdef/0/4",
                            obs_rdata, obs_err, obs_resp_cyc);
      end
   endtask

   task automatic test_back_to_back;
      run_txn(1'b1, 3'd2, 32'h6002, 32'h0000BEEF, 5, 0, 32'h0);
      n_checks++;
      if (obs_stable !== 1'b1 || obs_be !== 4'b1100 || obs_addr !== 32'h6000 || obs_wdata !== 32'hBEEFBEEF) begin
         n_fail++; $display("FAIL backpressure: got stable=%b be=%b addr=%h wdata=%h expected 1/1100/6000/beefbeef",
                            obs_stable, obs_be, obs_addr, obs_wdata);
      end
      n_checks++;
      if (obs_req_cycles !== 6 || obs_resp_cyc !== 8 || obs_err !== 1'b0) begin
         n_fail++; $display("FAIL backpressure_len: got req=%0d cyc=%0d err=%b expected 6/8/0",
                            obs_req_cycles, obs_resp_cyc, obs_err);
      end
   endtask

   task automatic test_random;
      logic        we, e_err;
      logic [2:0]  op;
      logic [31:0] addr, wd, rd, e_wd, e_rd;
      logic [3:0]  e_be;
      int          gd, rvd, e_cyc;
      for (int i = 0; i < 40; i++) begin
         we  = 1'($urandom_range(0, 1));
         op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         addr = $urandom; wd = $urandom; rd = $urandom;
         gd  = $urandom_range(0, 3); rvd = $urandom_range(0, 2);
         model(we, op, addr, wd, rd, e_err, e_be, e_wd, e_rd);
         run_txn(we, op, addr, wd, gd, rvd, rd);
         e_cyc = e_err ? 1 : gd + rvd + 3;
         n_checks++;
         if (obs_err !== e_err || obs_rdata !== e_rd || obs_resp_cyc !== e_cyc) begin
            n_fail++; $display("FAIL rand%0d_resp: we=%b op=%0d addr=%h got err=%b rdata=%h cyc=%0d expected %b/%h/%0d",
                               i, we, op, addr, obs_err, obs_rdata, obs_resp_cyc, e_err, e_rd, e_cyc);
         end
         if (!e_err) begin
            n_checks++;
            if (obs_addr !== {addr[31:2], 2'b00} || obs_be !== e_be || obs_wdata !== e_wd ||
                obs_we !== we || obs_stable !== 1'b1) begin
               n_fail++; $display("FAIL rand%0d_bus: got addr=%h be=%b wdata=%h we=%b stable=%b expected %h/%b/%h/%b/1",
                                  i, obs_addr, obs_be, obs_wdata, obs_we, obs_stable,
                                  {addr[31:2], 2'b00}, e_be, e_wd, we);
            end
         end else begin
            n_checks++;
            if (obs_bus_seen !== 1'b0) begin
               n_fail++; $display("FAIL rand%0d_nobus: got bus activity=%b expected 0", i, obs_bus_seen);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_sb();
      test_loads();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access engine for the RV32I core. It consumes the memory command the instruction decoder produces (`MemWr`, the 3-bit `MemOp` encoding, the ALU-computed address and rs2 store data). It performs one word-aligned bus transaction with byte enables and a request/grant/response handshake, then returns sign- or zero-extended load data to writeback. It is the receiving end of the decoder's memory-control outputs and sits between the execute stage and the data-memory bus.

## Interface
- `TIMEOUT`, default 255: bus cycles allowed from first `bus_req` to `bus_rvalid` before an error response is returned.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: core presents a memory command.
- `req_ready` output 1: block accepts a command. High only in IDLE.
- `req_we` input 1: 1 means store, 0 means load (decoder `MemWr`).
- `req_memop` input 3: 000 byte, 010 half, 100 word, 001 byte unsigned, 011 half unsigned.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data (rs2).
- `resp_valid` output 1: one-cycle pulse, response present.
- `resp_rdata` output 32: extended load data. 0 for stores and for errors.
- `resp_err` output 1: misaligned access, illegal op, or timeout. Qualified by `resp_valid`.
- `bus_req` output 1: bus request, held until `bus_gnt`.
- `bus_we` output 1: bus write.
- `bus_addr` output 32: `{req_addr[31:2], 2'b00}`.
- `bus_be` output 4: byte enables.
- `bus_wdata` output 32: lane-replicated store data.
- `bus_gnt` input 1: bus accepts the request in the cycle it is high while `bus_req` is high.
- `bus_rvalid` input 1: read data valid, or write acknowledge.
- `bus_rdata` input 32: read word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - `req_valid` high: the command is accepted and registered (we, memop, addr[1:0], lane data, be).
  - Legal and aligned command: go to REQ.
  - Otherwise: go to RESP with `resp_err` set, and no bus activity.
- **Illegal commands:** memop 101/110/111; a store with memop 001 or 011.
- **Misaligned commands:** a half with `addr[0]=1`; a word with `addr[1:0]≠0`.
- **REQ:** `bus_req` is high. On `bus_gnt`, go to WAIT.
- **WAIT:** on `bus_rvalid`, capture `bus_rdata` and go to RESP.
- **RESP:** `resp_valid` is high for exactly one cycle, then go to IDLE.
- **Byte enables:**
  - byte: `bus_be = 4'b0001 << addr[1:0]`.
  - half: `addr[1] ? 4'b1100 : 4'b0011`.
  - word: `4'b1111`.
  - Loads drive the same `bus_be`.
- **Store data:**
  - byte: `{4{wdata[7:0]}}`.
  - half: `{2{wdata[15:0]}}`.
  - word: unchanged.
  - Loads drive `bus_wdata = 0`.
- **Load extract:** shift `bus_rdata` right by `8*addr[1:0]`, take the low 8 or 16 bits, then sign-extend (000/010) or zero-extend (001/011). A word load passes through.
- **Timeout counter:** 8 bits minimum, sized to hold `TIMEOUT`.
  - Clears on entering REQ and increments in every REQ/WAIT cycle.
  - Reaching `TIMEOUT` forces RESP with `resp_err=1` and `resp_rdata=0`, and drops `bus_req`.
- `bus_rvalid` or `bus_gnt` arriving in IDLE or RESP is ignored.
- Store response: `resp_rdata=0` and `resp_err=0` on `bus_rvalid`.

## Timing
- **Reset values:**
  - `req_ready=1` (state IDLE). Commands presented while `rst_n` is low are not accepted.
  - All other outputs are 0: `resp_valid`, `resp_rdata`, `resp_err`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`.
- Accept at cycle T. `bus_req` and all bus outputs are registered and valid from T+1.
- Fastest bus (`bus_gnt` at T+1, `bus_rvalid` at T+2): `resp_valid` at T+3.
- Error path (illegal or misaligned): `resp_valid` and `resp_err` at T+1.
- Bus outputs hold stable from REQ entry until RESP. `bus_req` drops the cycle after the grant.
- `bus_rvalid` is not legal in the same cycle as `bus_gnt`. The earliest legal `bus_rvalid` is the cycle after the grant.
- Timeout and `bus_rvalid` in the same cycle: `bus_rvalid` wins, giving a normal response.
- `rst_n` asserted mid-transaction: the FSM returns to IDLE immediately and the transaction is abandoned. `bus_req` goes low asynchronously.
- Throughput: one command per 4 cycles at best. `req_ready` rises in the cycle after RESP.

## Structure
- Shared package `riscv_pkg`:
  - MemOp constants (`MEMOP_B`, `MEMOP_BU`, `MEMOP_H`, `MEMOP_HU`, `MEMOP_W`), shared with the decoder.
  - LSU state encoding.
- Sub-module `lsu_align`: combinational lane steering, containing the byte-enable generation, store replication, load extract/extension, and misalign/illegal detect.
- The top level holds the FSM, the registers and the timeout counter.

## Test plan
- **sw:** addr 0x1000, wdata 0xDEADBEEF, immediate grant, rvalid next cycle → `bus_addr=0x1000`, `be=1111`, `bus_wdata=0xDEADBEEF`, `resp_valid` at T+3 with `err=0`.
- **sb:** addr 0x1003, wdata 0x000000A5 → `be=1000`, `bus_wdata=0xA5A5A5A5`, `bus_addr=0x1000`.
- **Byte and half loads:**
  - lb at 0x2002 with `bus_rdata=0x12F45678` → `resp_rdata=0xFFFFFFF4`.
  - lbu at the same address → `0x000000F4`.
  - lhu at 0x2002 → `0x000012F4`.
- **Error path:**
  - lw at 0x3001 → no `bus_req`, `resp_valid` and `resp_err` at T+1.
  - store with memop 011 → same error response.
- **Timeout:** `TIMEOUT=8`, `bus_gnt` held low → after 8 REQ cycles `bus_req` drops and the response is `err=1`, `rdata=0`. A late `bus_rvalid` is ignored.
- **Reset and back-pressure:**
  - `rst_n` pulsed low during WAIT → all outputs return to reset values at once. A following lw completes normally.
  - Grant delayed 5 cycles → `bus_addr` and `bus_be` stay stable throughout.
